// File: rtl/prog_load_pkg.sv
// Shared types and constants for the program-load sequencer.
package prog_load_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    LEN,
    HI,
    LO,
    CHK,
    DONE,
    RUN,
    ERR
  } state_e;

  // Error codes reported on the err output
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_load_ctrl_byte_timeout.sv
// Clearable saturating cycle counter; expired stays high once TIMEOUT_CYC
// cycles have elapsed since the last clear.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT_CYC));

  // Next count: clear wins, otherwise count up and hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot/program-load sequencer: parses framed UART bytes into 16-bit words,
// writes them to program memory, checks an XOR checksum and holds the CPU
// in reset until a good load completes.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              mode,
  output logic              done,
  output logic [1:0]        err
);

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          acc_q, acc_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  err_e                err_q, err_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                mode_q, mode_d;
  logic                tmo_clear;
  logic                tmo_expired;

  // Any byte, restart or state change restarts the inter-byte timer
  assign tmo_clear = load_req | rx_valid | (state_d != state_q);

  byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .expired(tmo_expired)
  );

  // Next-state and datapath: load_req first, then per-state byte handling
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    cnt_d       = we_q ? cnt_q + 8'd1 : cnt_q;  // count advances after the write cycle
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    // CPU control follows the state with one cycle of lag
    cpu_reset_d = !((state_q == DONE) || (state_q == RUN));
    mode_d      = !((state_q == DONE) || (state_q == RUN));

    if (load_req) begin
      state_d = SYNC;
      done_d  = 1'b0;
      err_d   = ERR_NONE;
      cnt_d   = 8'd0;
      acc_d   = 8'd0;
    end else begin
      case (state_q)
        SYNC: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) state_d = LEN;
        end
        LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0) begin
              state_d = ERR;
              err_d   = ERR_LEN;
            end else begin
              len_d   = rx_data;
              acc_d   = rx_data;
              cnt_d   = 8'd0;
              state_d = HI;
            end
          end else if (tmo_expired) begin
            state_d = ERR;
            err_d   = ERR_TMO;
          end
        end
        HI: begin
          if (rx_valid) begin
            hi_d    = rx_data;
            acc_d   = acc_q ^ rx_data;
            state_d = LO;
          end else if (tmo_expired) begin
            state_d = ERR;
            err_d   = ERR_TMO;
          end
        end
        LO: begin
          if (rx_valid) begin
            acc_d   = acc_q ^ rx_data;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(cnt_q);
            wdata_d = {hi_q, rx_data};
            state_d = ((cnt_q + 8'd1) == len_q) ? CHK : HI;
          end else if (tmo_expired) begin
            state_d = ERR;
            err_d   = ERR_TMO;
          end
        end
        CHK: begin
          if (rx_valid) begin
            if (rx_data == acc_q) begin
              state_d = DONE;
            end else begin
              state_d = ERR;
              err_d   = ERR_CHK;
            end
          end else if (tmo_expired) begin
            state_d = ERR;
            err_d   = ERR_TMO;
          end
        end
        DONE: begin
          state_d = RUN;
          done_d  = 1'b1;
        end
        default: ;  // IDLE, RUN, ERR wait for load_req
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      acc_q       <= 8'd0;
      hi_q        <= 8'd0;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
      cpu_reset_q <= 1'b1;
      mode_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      mode_q      <= mode_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign mode      = mode_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: directed frame table, hand-written abort and
// async-reset sequences, and random frames checked against a frame-level model.
module tb_prog_load_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        load_req = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        mode;
  logic        done;
  logic [1:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] wr_seen[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  stim[$];
  logic [1:0]  exp_err;
  logic        exp_done;

  prog_load_ctrl #(
    .ADDR_W     (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .load_req (load_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .mode     (mode),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Record every cycle with mem_we high; a multi-cycle strobe shows up as extra writes
  always @(negedge clk) begin
    if (mem_we) wr_seen.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic send_stim(input int gap_max);
    foreach (stim[i]) send_byte(stim[i], $urandom_range(gap_max, 0));
  endtask

  // Pulse load_req and confirm the restart cleared status and re-held the CPU
  task automatic start_load(input string tag);
    wr_seen.delete();
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    cyc();
    check({tag, ".start_err"}, 32'(err), 32'd0);
    check({tag, ".start_done"}, 32'(done), 32'd0);
    check({tag, ".start_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, ".start_mode"}, 32'(mode), 32'd1);
  endtask

  // Let the frame settle; for a timeout, also confirm it does not fire early
  task automatic finish_frame(input string tag);
    if (exp_err == 2'd3) begin
      repeat (TMO - 5) cyc();
      check({tag, ".no_early_tmo"}, 32'(err), 32'd0);
      repeat (15) cyc();
    end else begin
      repeat (4) cyc();
    end
  endtask

  task automatic check_result(input string tag);
    int n;
    check({tag, ".nwr"}, 32'(wr_seen.size()), 32'(exp_wr.size()));
    n = (wr_seen.size() < exp_wr.size()) ? wr_seen.size() : exp_wr.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.wr%0d", tag, i), 32'(wr_seen[i]), 32'(exp_wr[i]));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".mode"}, 32'(mode), 32'(!exp_done));
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    $display("[TB] frame %s: bytes=%0d writes=%0d err=%0d done=%0b",
             tag, stim.size(), wr_seen.size(), err, done);
  endtask

  // Frame-level reference: walk the byte list by the framing rules
  task automatic model();
    int i;
    int n;
    logic [7:0] acc;
    logic [7:0] hi;
    logic [7:0] lo;
    exp_wr.delete();
    exp_err  = 2'd0;
    exp_done = 1'b0;
    i = 0;
    while (i < stim.size() && stim[i] != 8'hA5) i++;
    i++;
    if (i >= stim.size()) begin exp_err = 2'd3; return; end
    n = int'(stim[i]);
    i++;
    if (n == 0) begin exp_err = 2'd1; return; end
    acc = 8'(n);
    for (int k = 0; k < n; k++) begin
      if (i + 1 >= stim.size()) begin exp_err = 2'd3; return; end
      hi = stim[i];
      lo = stim[i+1];
      i += 2;
      acc = acc ^ hi ^ lo;
      exp_wr.push_back({8'(k), hi, lo});
    end
    if (i >= stim.size()) begin exp_err = 2'd3; return; end
    exp_err  = (stim[i] == acc) ? 2'd0 : 2'd2;
    exp_done = (exp_err == 2'd0);
  endtask

  typedef struct {
    logic [0:7][7:0] b;
    int              nb;
    int              nwr;
    logic [15:0]     w0;
    logic [15:0]     w1;
    logic [1:0]      err;
    logic            done;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{b: {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A, 8'h00}, nb: 7,
              nwr: 2, w0: 16'h1234, w1: 16'h5678, err: 2'd0, done: 1'b1};
    vt[1] = '{b: {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B, 8'h00}, nb: 7,
              nwr: 2, w0: 16'h1234, w1: 16'h5678, err: 2'd2, done: 1'b0};
    vt[2] = '{b: {8'h33, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 3,
              nwr: 0, w0: 16'h0000, w1: 16'h0000, err: 2'd1, done: 1'b0};
    vt[3] = '{b: {8'hA5, 8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 3,
              nwr: 0, w0: 16'h0000, w1: 16'h0000, err: 2'd3, done: 1'b0};

    // Reset state
    repeat (3) cyc();
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst.mode", 32'(mode), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Directed frame table, bytes back to back
    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      stim.delete();
      for (int j = 0; j < vt[v].nb; j++) stim.push_back(vt[v].b[j]);
      exp_wr.delete();
      if (vt[v].nwr > 0) exp_wr.push_back({8'd0, vt[v].w0});
      if (vt[v].nwr > 1) exp_wr.push_back({8'd1, vt[v].w1});
      exp_err  = vt[v].err;
      exp_done = vt[v].done;
      start_load(tag);
      send_stim(0);
      finish_frame(tag);
      check_result(tag);
    end

    // Mid-frame restart: load_req together with a byte drops the byte
    start_load("abort");
    stim = '{8'hA5, 8'h02, 8'h12};
    send_stim(0);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    cyc();
    load_req = 1'b0;
    rx_valid = 1'b0;
    cyc();
    stim = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67};
    exp_wr.delete();
    exp_wr.push_back({8'd0, 16'hABCD});
    exp_err  = 2'd0;
    exp_done = 1'b1;
    send_stim(1);
    finish_frame("abort");
    check_result("abort");

    // Asynchronous reset in LO: outputs return without a clock edge
    start_load("arst");
    stim = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56};
    send_stim(0);
    check("arst.pre_wdata", 32'(mem_wdata), 32'h1234);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.mem_we", 32'(mem_we), 32'd0);
    check("arst.mem_addr", 32'(mem_addr), 32'd0);
    check("arst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("arst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst.mode", 32'(mode), 32'd1);
    check("arst.done", 32'(done), 32'd0);
    check("arst.err", 32'(err), 32'd0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    // Bytes in IDLE are ignored
    wr_seen.delete();
    stim = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
    send_stim(0);
    repeat (4) cyc();
    check("idle_ignore.nwr", 32'(wr_seen.size()), 32'd0);
    check("idle_ignore.done", 32'(done), 32'd0);

    // Random frames against the frame-level model
    for (int r = 0; r < 40; r++) begin
      string tag;
      int junk;
      int len;
      logic [7:0] chk;
      logic [7:0] b;
      tag = $sformatf("rand%0d", r);
      stim.delete();
      junk = $urandom_range(2, 0);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      stim.push_back(8'hA5);
      len = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(6, 1);
      stim.push_back(8'(len));
      chk = 8'(len);
      for (int j = 0; j < 2 * len; j++) begin
        b = 8'($urandom_range(255, 0));
        chk ^= b;
        stim.push_back(b);
      end
      if (len != 0) begin
        if ($urandom_range(3, 0) == 0) chk ^= 8'(1 << $urandom_range(7, 0));
        stim.push_back(chk);
        if ($urandom_range(7, 0) == 0) begin
          int cut;
          cut = $urandom_range(3, 1);
          for (int j = 0; j < cut; j++)
            if (stim.size() > junk + 1) void'(stim.pop_back());
        end
      end
      model();
      start_load(tag);
      send_stim(3);
      finish_frame(tag);
      check_result(tag);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Boot/program-load sequencer between the UART byte receiver and the 16-bit program memory feeding MAR/MDR.
- Parses a framed byte stream, assembles 16-bit instruction words and writes them to sequential program addresses.
- Verifies an XOR checksum.
- Holds the CPU core in reset while loading; releases it only after a good load.
- Drives the 7-segment `mode` indication.

Parameters:
- ADDR_W, 8: program memory address width.
- TIMEOUT_CYC, 1000000: maximum clk cycles allowed between bytes once a frame has started.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received UART byte
- load_req  in  1  one-cycle debounced button pulse: start or restart a load
- mem_we  out  1  program memory write strobe
- mem_addr  out  ADDR_W  program memory write address
- mem_wdata  out  16  program word, {hi, lo}
- cpu_reset  out  1  holds PC/SC/CU in reset while high
- mode  out  1  1 = load mode, 0 = run mode
- done  out  1  sticky: last load succeeded
- err  out  2  0 none, 1 zero length, 2 checksum mismatch, 3 timeout

Behaviour:
- Reset (async on reset_n low), all registered:
  - state = IDLE, cpu_reset = 1, mode = 1, mem_we = 0
  - mem_addr = 0, mem_wdata = 0, done = 0, err = 0
  - word count = 0, checksum accumulator = 0
- Frame format:
  - SYNC_BYTE, then LEN (N words, 1..255).
  - Then N pairs of hi byte, lo byte.
  - Then CHK = XOR of LEN and all data bytes.
- States:
  - IDLE: wait for load_req -> SYNC.
  - SYNC: rx_valid && rx_data == SYNC_BYTE -> LEN. Other bytes are ignored; no timeout applies.
  - LEN:
    - N == 0 -> ERR, err = 1.
    - Otherwise latch N, acc = N, count = 0 -> HI.
  - HI: latch hi byte, acc ^= byte -> LO.
  - LO: acc ^= byte, then -> CHK if count+1 == N, else HI.
  - CHK: byte == acc -> DONE; otherwise -> ERR, err = 2.
  - DONE: single cycle. Sets done = 1, cpu_reset = 0, mode = 0 -> RUN.
  - RUN: CPU executes. load_req -> SYNC.
  - ERR: cpu_reset = 1, mode = 1. load_req -> SYNC.
- Write timing:
  - On the cycle after an accepted LO byte, mem_we = 1 for exactly one cycle.
  - In that cycle mem_addr = count and mem_wdata = {hi, lo}; count then increments.
  - A byte arriving in the mem_we cycle is accepted normally, because the write uses latched registers.
- Entering SYNC from any state:
  - cpu_reset = 1, mode = 1, done = 0, err = 0, count = 0, acc = 0.
  - Timeout counter is cleared.
- cpu_reset and mode are registered outputs; they change the cycle after the state change.
- Timeout:
  - Counter clears on every rx_valid and on every state entry.
  - In LEN/HI/LO/CHK, reaching TIMEOUT_CYC -> ERR, err = 3.
  - The partially written memory is left as is.
- Precedence:
  - load_req beats rx_valid in the same cycle; the byte is dropped.
  - load_req during an active load aborts it and restarts at SYNC.
- rx_valid is ignored in IDLE, RUN, ERR and DONE.
- mem_addr is ADDR_W wide. N <= 255 guarantees no address wrap.
- mem_we is never asserted outside the write cycle.

Decomposition:
- Shared package `prog_load_pkg` holds:
  - state enum: IDLE, SYNC, LEN, HI, LO, CHK, DONE, RUN, ERR
  - err codes: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO
  - SYNC_BYTE default
- One sub-module: `byte_timeout`, a parameterised clearable counter with a `clear` input and an `expired` output.

Test Plan:
- Reset, then load_req, then bytes A5 02 12 34 56 78 0A:
  - writes 0x1234 @0 and 0x5678 @1, each mem_we one cycle
  - afterwards done = 1, err = 0, mode = 0, cpu_reset = 0
- Same frame with CHK = 0x0B:
  - both words written, then err = 2, done = 0, cpu_reset stays 1
- load_req, then 33 A5 00:
  - 33 ignored in SYNC, then err = 1, no mem_we
- load_req, then A5 01 12, then no bytes for TIMEOUT_CYC cycles:
  - err = 3, no mem_we
  - a following load_req clears err to 0
- Mid-frame load_req after A5 02 12 (sent together with rx_valid of a byte):
  - byte dropped, state SYNC, count = 0
  - a full new frame then loads from address 0
- Async reset_n low during LO:
  - all outputs return to reset values immediately, without waiting for a clock edge
